vertex_stream_loader: RTL and testbench

- Upstream feeder for the vertex-processor data memory.
- Accepts a 32-bit component stream over a valid/ready handshake and packs four components (x, y, z, w) into one 128-bit vertex.
- Writes each vertex through the memory's general-data write port (vert_in / addr_inf / we_inf) at consecutive addresses from a programmed base.
- Signals completion so the vertex processor can start.

---
 rtl/vp_pkg.sv | 16 +
 rtl/vertex_packer.sv | 42 ++++
 rtl/vertex_stream_loader.sv | 87 ++++++++
 tb/tb_vertex_stream_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// vp_pkg: shared constants and types for the vertex stream loader
// Macro: VLOAD_DEFAULT_W_EN selects 3-component vertices with w forced to 1.0f
package vp_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 128;
    localparam int COMP_W = 32;
    localparam int CNT_W  = 9;
    localparam logic [31:0] F32_ONE = 32'h3F800000;
`ifdef VLOAD_DEFAULT_W_EN
    localparam logic [1:0] LAST_COMP = 2'd2;
`else
    localparam logic [1:0] LAST_COMP = 2'd3;
`endif
    typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_t;
    typedef logic [1:0] comp_idx_t;
endpackage

// File: rtl/vertex_packer.sv
// vertex_packer: packs handshaken stream components into one vertex
// Ports: clk, rst_n (async active-low); hs = accepted word; clear = drop partial vertex;
//        data = incoming component; vertex = packed vertex including the current word;
//        complete = this handshake carries the last component of a vertex.
// Macro: VLOAD_DEFAULT_W_EN forces the w slot to 1.0f and wraps after z.
module vertex_packer import vp_pkg::*; #(
    parameter int COMP_W = vp_pkg::COMP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hs,
    input  logic                  clear,
    input  logic [COMP_W-1:0]     data,
    output logic [4*COMP_W-1:0]   vertex,
    output logic                  complete
);
    comp_idx_t idx;
    // Ascending packed range puts slot 0 (x) in the most significant bits.
    logic [0:3][COMP_W-1:0] pack, merged;
    assign complete = hs && idx == LAST_COMP;
    assign vertex = merged;
    // Merge the word being accepted so the top can register the full vertex on that edge.
    always_comb begin
        merged = pack;
        if (hs) merged[idx] = data;
`ifdef VLOAD_DEFAULT_W_EN
        merged[3] = F32_ONE;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            pack <= '0;
        end else if (clear) begin
            idx  <= '0;
            pack <= '0;
        end else if (hs) begin
            pack[idx] <= data;
            idx       <= complete ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/vertex_stream_loader.sv
// vertex_stream_loader: loads a component stream as packed vertices into data memory
// Ports: clk, rst_n (async active-low); start/abort control; base_addr, vert_count latched on start;
//        s_valid/s_data/s_ready component stream; vert_in/addr_inf/we_inf memory write port;
//        busy high while loading; done one-cycle completion pulse.
// Macro: VLOAD_DEFAULT_W_EN selects 3-component vertices with w forced to 1.0f.
module vertex_stream_loader import vp_pkg::*; #(
    parameter int ADDR_W = vp_pkg::ADDR_W,
    parameter int DATA_W = vp_pkg::DATA_W,
    parameter int COMP_W = vp_pkg::COMP_W,
    parameter int CNT_W  = vp_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  vert_count,
    input  logic              s_valid,
    input  logic [COMP_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] vert_in,
    output logic [ADDR_W-1:0] addr_inf,
    output logic              we_inf,
    output logic              busy,
    output logic              done
);
    load_state_t       state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] vertex;
    logic              complete;
    logic              hs;
    assign s_ready = state == LOAD;
    assign hs = s_valid && s_ready;
    vertex_packer #(.COMP_W(COMP_W)) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .hs       (hs),
        .clear    (abort),
        .data     (s_data),
        .vertex   (vertex),
        .complete (complete)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            vert_in   <= '0;
            addr_inf  <= '0;
            we_inf    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            we_inf <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    addr      <= base_addr;
                    remaining <= vert_count;
                    state     <= vert_count == '0 ? DONE : LOAD;
                    busy      <= vert_count != '0;
                end
                LOAD: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (complete) begin
                    vert_in   <= vertex;
                    addr_inf  <= addr;
                    we_inf    <= 1'b1;
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    // Leaving LOAD here drops s_ready on the very next cycle.
                    if (remaining == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vertex_stream_loader.sv
// tb_vertex_stream_loader: scoreboard bench for vertex_stream_loader
module tb_vertex_stream_loader;
    import vp_pkg::*;
`ifdef VLOAD_DEFAULT_W_EN
    localparam int NC = 3;
`else
    localparam int NC = 4;
`endif
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [7:0]   base_addr = '0;
    logic [8:0]   vert_count = '0;
    logic         s_valid = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_ready;
    logic [127:0] vert_in;
    logic [7:0]   addr_inf;
    logic         we_inf;
    logic         busy;
    logic         done;
    int pass_cnt = 0, chk_cnt = 0;
    int cyc = 0, st_cyc = 0, done_cyc = 0, we_cyc = 0;
    int done_cnt = 0, we_cnt = 0, ready_cnt = 0;
    logic [135:0] sb[$];

    vertex_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .vert_count(vert_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .vert_in(vert_in), .addr_inf(addr_inf), .we_inf(we_inf),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [127:0] vtx(input int first);
        logic [127:0] v;
        for (int k = 0; k < 4; k++)
            v[127-32*k -: 32] = (k < NC) ? 32'(first + k) : F32_ONE;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_ready) ready_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (we_inf) begin
                logic [135:0] e;
                we_cnt++;
                we_cyc = cyc;
                if (sb.size() == 0) check("we_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("wr_addr", addr_inf, e[135:128]);
                    check("wr_data", vert_in, e[127:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [7:0] b, input logic [8:0] c);
        base_addr = b;
        vert_count = c;
        start = 1'b1;
        st_cyc = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic send(input int v, input bit gaps);
        int t = 0;
        s_valid = 1'b1;
        s_data = 32'(v);
        while (!s_ready && t < 50) begin
            step(1);
            t++;
        end
        if (t >= 50) check("send_timeout", 0, 1);
        step(1);
        s_valid = 1'b0;
        if (gaps) step(1);
    endtask

    task automatic wait_done(input int d0);
        for (int t = 0; t < 20 && done_cnt == d0; t++) step(1);
        step(1);
        check("done_count", done_cnt - d0, 1);
    endtask

    task automatic load(input logic [7:0] b, input logic [8:0] c, input int first, input bit gaps);
        int d0 = done_cnt;
        for (int v = 0; v < int'(c); v++) begin
            logic [7:0] a = b + 8'(v);
            sb.push_back({a, vtx(first + v * NC)});
        end
        go(b, c);
        check("busy_load", busy, 1);
        for (int v = 0; v < int'(c); v++)
            for (int k = 0; k < NC; k++) send(first + v * NC + k, gaps);
        wait_done(d0);
        check("done_after_we", done_cyc - we_cyc, 1);
        check("busy_after", busy, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int d0, w0, r0;
        step(1);
        check("rst_s_ready", s_ready, 0);
        check("rst_we_inf", we_inf, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vert_in", vert_in, 0);
        check("rst_addr_inf", addr_inf, 0);
        rst_n = 1'b1;
        step(2);
        // basic load, then the same with backpressure gaps
        load(8'h10, 9'd2, 1, 1'b0);
        load(8'h10, 9'd2, 1, 1'b1);
        // address wrap
        load(8'hFF, 9'd2, 101, 1'b0);
        // zero count
        d0 = done_cnt; w0 = we_cnt; r0 = ready_cnt;
        go(8'h30, 9'd0);
        wait_done(d0);
        check("zero_done_lat", done_cyc - st_cyc, 2);
        check("zero_no_we", we_cnt - w0, 0);
        check("zero_no_ready", ready_cnt - r0, 0);
        // abort during the second vertex
        d0 = done_cnt; w0 = we_cnt;
        sb.push_back({8'h40, vtx(201)});
        go(8'h40, 9'd2);
        for (int k = 0; k < NC + 2; k++) send(201 + k, 1'b0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_ready", s_ready, 0);
        check("abort_busy", busy, 0);
        step(5);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_one_we", we_cnt - w0, 1);
        load(8'h20, 9'd1, 301, 1'b0);
        // abort together with start in IDLE
        d0 = done_cnt;
        abort = 1'b1;
        go(8'h70, 9'd1);
        abort = 1'b0;
        check("abort_start_ready", s_ready, 0);
        step(4);
        check("abort_start_no_done", done_cnt - d0, 0);
        // async reset mid-load
        d0 = done_cnt;
        sb.push_back({8'h50, vtx(401)});
        go(8'h50, 9'd2);
        for (int k = 0; k < NC + 2; k++) send(401 + k, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_s_ready", s_ready, 0);
        check("mrst_busy", busy, 0);
        check("mrst_vert_in", vert_in, 0);
        check("mrst_addr_inf", addr_inf, 0);
        check("mrst_we_inf", we_inf, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("mrst_no_done", done_cnt - d0, 0);
        load(8'h60, 9'd1, 501, 1'b0);
        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
